// File: rtl/ofifo_pkg.sv
// Shared constants, lane type and pointer-width helper for the output deskew FIFO.
package ofifo_pkg;

  localparam int unsigned COL_DEF     = 8;
  localparam int unsigned PSUM_BW_DEF = 16;
  localparam int unsigned DEPTH_DEF   = 64;

  typedef logic signed [PSUM_BW_DEF-1:0] psum_t;

  // One extra MSB distinguishes full from empty when the index bits match.
  function automatic int unsigned ptr_w(input int unsigned d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/ofifo_column.sv
// Single-column FIFO: storage, wrap-bit pointers, full/empty decode and sticky overflow.
module ofifo_column
  import ofifo_pkg::*;
#(
  parameter int unsigned psum_bw = PSUM_BW_DEF,
  parameter int unsigned depth   = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_i,
  input  logic               pop_i,
  input  logic [psum_bw-1:0] din_i,
  output logic [psum_bw-1:0] dout_o,
  output logic               empty_o,
  output logic               full_o,
  output logic               ovf_o
);

  localparam int unsigned PW = ptr_w(depth);
  localparam int unsigned AW = PW - 1;

  logic [PW-1:0]      wptr_q, wptr_d;
  logic [PW-1:0]      rptr_q, rptr_d;
  logic               ovf_q, ovf_d;
  logic               wr_acc;
  logic [psum_bw-1:0] mem_q [depth];

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign ovf_o   = ovf_q;
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  // A full column still accepts a write when the head is popped on the same edge.
  assign wr_acc = wr_i & (~full_o | pop_i);

  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, wr_acc};
    rptr_d = rptr_q + {{AW{1'b0}}, pop_i};
    ovf_d  = ovf_q | (wr_i & full_o & ~pop_i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !reset) begin
      mem_q[wptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/ofifo_deskew.sv
// Per-column psum FIFOs presenting a time-aligned row through a valid/read handshake.
// Optional build macro OFIFO_RELU_EN applies ReLU to each output lane.
module ofifo_deskew
  import ofifo_pkg::*;
#(
  parameter int unsigned col     = COL_DEF,
  parameter int unsigned psum_bw = PSUM_BW_DEF,
  parameter int unsigned depth   = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ovf
);

  logic [col-1:0]         empty_w;
  logic [col-1:0]         full_w;
  logic [col-1:0]         ovf_w;
  logic [psum_bw*col-1:0] head_w;
  logic                   pop;

  for (genvar c = 0; c < col; c++) begin : g_col
    ofifo_column #(
      .psum_bw(psum_bw),
      .depth  (depth)
    ) u_col (
      .clk    (clk),
      .reset  (reset),
      .wr_i   (wr[c]),
      .pop_i  (pop),
      .din_i  (in[psum_bw*c +: psum_bw]),
      .dout_o (head_w[psum_bw*c +: psum_bw]),
      .empty_o(empty_w[c]),
      .full_o (full_w[c]),
      .ovf_o  (ovf_w[c])
    );
  end

  assign o_valid = ~|empty_w;
  assign o_full  = |full_w;
  assign o_ovf   = |ovf_w;
  assign pop     = rd & o_valid;

  always_comb begin
    logic [psum_bw-1:0] lane;
    lane = '0;
    out  = '0;
    if (o_valid) begin
      for (int unsigned c = 0; c < col; c++) begin
        lane = head_w[psum_bw*c +: psum_bw];
`ifdef OFIFO_RELU_EN
        if (lane[psum_bw-1]) lane = '0;
`else
`endif
        out[psum_bw*c +: psum_bw] = lane;
      end
    end
  end

endmodule

// File: doc/ofifo_deskew.md
# ofifo_deskew

Output-side collector for the systolic MAC array. It takes the per-column partial-sum stream (`out_s`) and the per-column `valid` strobes from the array. Because instructions ripple down the rows, columns finish on different cycles, so each column gets its own FIFO. The block presents a full, time-aligned row of `col` psums to the downstream reader (psum SRAM writer / accumulator) through a valid/read handshake.

## Interface
- `col`, 8: number of array columns (one FIFO each).
- `psum_bw`, 16: width of one signed partial sum.
- `depth`, 64: entries per column FIFO; must be a power of two, ≥2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `in` input `psum_bw*col`: psum row from the array; column c occupies bits `[psum_bw*c +: psum_bw]`.
- `wr` input `col`: per-column write strobe, driven directly by the array `valid`.
- `rd` input 1: reader pops one aligned row.
- `out` output `psum_bw*col`: aligned head row, same column packing as `in`.
- `o_valid` output 1: every column FIFO is non-empty.
- `o_full` output 1: at least one column FIFO is full.
- `o_ovf` output 1: sticky overflow flag; a write was dropped.

## Operation
- Each column c is an independent FIFO. A write is accepted when `wr[c]=1` and the column is not full, or when `wr[c]=1`, the column is full, and a pop happens on the same edge.
- A write to a full column with no same-cycle pop is dropped: data discarded, pointers unchanged, `o_ovf` set to 1.
- Pop condition: `rd & o_valid`. On a pop, all `col` FIFOs advance their read pointers together.
- `rd` while `o_valid=0` is ignored; no pointer moves and no error is flagged.
- Pointers are `$clog2(depth)+1` bits wide and wrap modulo `2*depth`:
  - empty: read pointer == write pointer.
  - full: the MSBs differ and the remaining bits are equal.
- Simultaneous write and pop on the same column: both take effect, and occupancy is unchanged.
- Writing to an empty column does not affect `o_valid` in that same cycle (no bypass).
- `out` is first-word-fall-through from the heads of the column FIFOs. When `o_valid=0`, `out` is forced to 0.
- `o_valid`: AND of all column not-empty flags. `o_full`: OR of all column full flags. Both are decoded from registered pointers, with no combinational path from `rd` or `wr`.
- Data is passed through unmodified except as described under Configuration.

## Timing
- Reset values: all pointers 0, `o_valid=0`, `o_full=0`, `o_ovf=0`, `out=0`. Memory contents are not reset.
- Reset asserted mid-operation discards all queued rows immediately. The first write after reset deasserts lands in entry 0.
- Write latency: data written at edge N is visible at `out` after edge N, provided all other columns are also non-empty at that point.
- Staggered input, where column c's strobe arrives c cycles after column 0: `o_valid` rises the cycle after the last column's first write.
- Read latency: the pop at edge N exposes the next head row after edge N. Sustained throughput is one row per cycle.
- `o_ovf` clears only on reset.

## Configuration
- `OFIFO_RELU_EN` defined: each `psum_bw` lane of `out` is passed through ReLU. A negative value (MSB=1) reads as 0; stored data is unchanged.
- `OFIFO_RELU_EN` undefined: `out` is the raw stored signed value.
- The forced-0 behaviour while `o_valid=0` applies in both builds.

## Structure
- Shared package `ofifo_pkg`: default `col`, `psum_bw` and `depth` constants, a pointer-width function `ptr_w(depth)=$clog2(depth)+1`, and the psum lane typedef.
- One sub-module, `ofifo_column`: a single-column FIFO with data, pointers, and full/empty/overflow flags. `ofifo_deskew` instantiates `col` copies in a generate loop and does the handshake, flag reduction and ReLU.

## Test plan
- **Reset during traffic:** fill 10 rows, assert `reset` mid-cycle → `o_valid`, `o_full`, `o_ovf` and `out` go to 0 asynchronously. After release, the first row written reads back first.
- **Staggered fill:** `col=8`, `wr[c]` pulsed at cycle c with lane value `16'h0100+c` → `o_valid` rises after cycle 7, and `out` shows `0100..0107` in lanes 0..7. Popping that row empties the FIFO.
- **Full and overflow:** 64 writes on all columns → `o_full=1`. A 65th write without `rd` leaves `o_ovf=1` and keeps the head at row 0. A 65th write with `rd` in the same cycle is accepted, `o_ovf` stays 0 and occupancy stays 64.
- **Pointer wrap:** stream 200 rows with continuous write and read at 1 row/cycle → every row is read back in order with no loss, and `o_full` never asserts.
- **Read while empty:** hold `rd=1` with only columns 0–6 written → no pop and `out=0`. Writing column 7 raises `o_valid` on the next cycle.
- **ReLU:** write lane value `16'hFFF0` (−16) and `16'h0010` (16). With `OFIFO_RELU_EN` defined, `out` shows 0 and 16. Without it, `out` shows `FFF0` and `0010`.
